// File: rtl/prog_counter_sync.sv
// Programmable limit counter (up / down / ping-pong / one-shot) with input synchronisers.
// Optional tick prescaler enabled by defining CNTR_PRESCALE_EN.
module prog_counter_sync #(
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int CLEAR_ON_DIS = 1,
    parameter int PRESCALE     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             dir
);

    typedef enum logic [1:0] {
        MODE_UP      = 2'b00,
        MODE_DOWN    = 2'b01,
        MODE_PING    = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    if (WIDTH < 2 || WIDTH > 16 || SYNC_STAGES < 1 || SYNC_STAGES > 4 ||
        PRESCALE < 2 || PRESCALE > 256) begin : g_bad_param
        $error("prog_counter_sync: parameter out of supported range");
    end

    logic             r_en_sync    [SYNC_STAGES];
    logic [WIDTH-1:0] r_limit_sync [SYNC_STAGES];
    mode_e            r_mode_sync  [SYNC_STAGES];
    mode_e            r_mode_prev;

    logic [WIDTH-1:0] r_count;
    logic             r_done;
    logic             r_dir;

    logic             w_en_s;
    logic [WIDTH-1:0] w_limit_s;
    mode_e            w_mode_s;
    logic [WIDTH-1:0] w_start;
    logic             w_dir_rest;
    logic             w_mode_chg;
    logic             w_tick;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_done_nxt;
    logic             w_dir_nxt;

    // NOTE: the synchroniser stages are plain flops, so they are reset with everything else;
    // non-blocking assignments let every stage shift on the same edge regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_en_sync[i]    <= 1'b0;
                r_limit_sync[i] <= '0;
                r_mode_sync[i]  <= MODE_UP;
            end
        end else begin
            r_en_sync[0]    <= en;
            r_limit_sync[0] <= limit;
            r_mode_sync[0]  <= mode_e'(mode);
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_en_sync[i]    <= r_en_sync[i-1];
                r_limit_sync[i] <= r_limit_sync[i-1];
                r_mode_sync[i]  <= r_mode_sync[i-1];
            end
        end
    end

    assign w_en_s     = r_en_sync[SYNC_STAGES-1];
    assign w_limit_s  = r_limit_sync[SYNC_STAGES-1];
    assign w_mode_s   = r_mode_sync[SYNC_STAGES-1];
    assign w_start    = (w_mode_s == MODE_DOWN) ? w_limit_s : '0;
    assign w_dir_rest = (w_mode_s != MODE_DOWN);
    assign w_mode_chg = (w_mode_s != r_mode_prev);

`ifdef CNTR_PRESCALE_EN
    localparam int PSC_W = $clog2(PRESCALE);
    logic [PSC_W-1:0] r_psc;

    always_ff @(posedge clk) begin
        if (rst || !w_en_s || w_mode_chg || w_tick) begin
            r_psc <= '0;
        end else begin
            r_psc <= r_psc + PSC_W'(1);
        end
    end

    assign w_tick = w_en_s && (r_psc == PSC_W'(PRESCALE - 1));
`else
    assign w_tick = w_en_s;
`endif

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        w_dir_nxt   = r_dir;
        if (!w_en_s) begin
            w_dir_nxt   = w_dir_rest;
            w_count_nxt = (CLEAR_ON_DIS != 0) ? w_start : r_count;
        end else if (w_mode_chg) begin
            w_dir_nxt   = w_dir_rest;
            w_count_nxt = w_start;
        end else if (w_tick) begin
            unique case (w_mode_s)
                MODE_UP: begin
                    w_dir_nxt = 1'b1;
                    if (r_count < w_limit_s) begin
                        w_count_nxt = r_count + WIDTH'(1);
                    end else begin
                        w_count_nxt = '0;
                        w_done_nxt  = 1'b1;
                    end
                end
                MODE_DOWN: begin
                    w_dir_nxt = 1'b0;
                    if (r_count > w_limit_s) begin
                        w_count_nxt = w_limit_s;
                    end else if (r_count != '0) begin
                        w_count_nxt = r_count - WIDTH'(1);
                    end else begin
                        w_count_nxt = w_limit_s;
                        w_done_nxt  = 1'b1;
                    end
                end
                MODE_PING: begin
                    if (r_dir) begin
                        if (r_count >= w_limit_s) begin
                            w_count_nxt = (w_limit_s == '0) ? '0 : w_limit_s - WIDTH'(1);
                            w_dir_nxt   = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_count_nxt = r_count + WIDTH'(1);
                        end
                    end else begin
                        if (r_count == '0) begin
                            w_count_nxt = (w_limit_s == '0) ? '0 : WIDTH'(1);
                            w_dir_nxt   = 1'b1;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_count_nxt = r_count - WIDTH'(1);
                        end
                    end
                end
                MODE_ONESHOT: begin
                    // done is a sticky level here; only disable, mode change or reset clear it
                    w_dir_nxt = 1'b1;
                    if (r_count < w_limit_s) begin
                        w_count_nxt = r_count + WIDTH'(1);
                        w_done_nxt  = r_done;
                    end else begin
                        w_count_nxt = w_limit_s;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            w_done_nxt = (w_mode_s == MODE_ONESHOT) && r_done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_done      <= 1'b0;
            r_dir       <= 1'b1;
            r_mode_prev <= MODE_UP;
        end else begin
            r_count     <= w_count_nxt;
            r_done      <= w_done_nxt;
            r_dir       <= w_dir_nxt;
            r_mode_prev <= w_mode_s;
        end
    end

    assign count = r_count;
    assign done  = r_done;
    assign dir   = r_dir;

endmodule
